// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MD_CANCEL_EN to add a `cancel` input that aborts an in-flight op or suppresses an issue.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             kill;

`ifdef MD_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    // Result datapath works on the latched operands so it is stable for the whole RUN.
    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, divisor, quo_u, rem_u, quo, rem;
    logic        signed_div, div_by_zero;

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign signed_div  = (op_q == OP_DIV);
    assign div_by_zero = (b_q == 32'd0);
    assign mag_a       = (signed_div && a_q[31]) ? -a_q : a_q;
    assign mag_b       = (signed_div && b_q[31]) ? -b_q : b_q;
    assign divisor     = div_by_zero ? 32'd1 : mag_b;
    assign quo_u       = mag_a / divisor;
    assign rem_u       = mag_a % divisor;
    assign quo         = (signed_div && (a_q[31] ^ b_q[31])) ? -quo_u : quo_u;
    assign rem         = (signed_div && a_q[31]) ? -rem_u : rem_u;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    case (md_op_e'(md_op))
                        OP_MULT, OP_MULTU: begin
                            state_d = S_RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            op_d    = md_op_e'(md_op);
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            op_d    = md_op_e'(md_op);
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (kill) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        case (op_q)
                            OP_MULT:  {hi_d, lo_d} = prod_s;
                            OP_MULTU: {hi_d, lo_d} = prod_u;
                            OP_DIV, OP_DIVU: begin
                                if (!div_by_zero) begin
                                    lo_d = quo;
                                    hi_d = rem;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset clears everything, discarding any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (MULT_CYCLES=5, DIV_CYCLES=10).
// The cancel scenario is included only when MD_CANCEL_EN is defined.
module tb_md_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        busy;
    logic [31:0] HI, LO;
`ifdef MD_CANCEL_EN
    logic        cancel = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
        md_op = 3'd0;
    endtask

    // Counts sampled cycles with busy high; the bound turns a stuck busy into a failed check.
    task automatic busy_cycles(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            step();
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b);
        busy_cycles(n);
        check({tag, ".cycles"}, n, exp_n);
        check({tag, ".hi"}, HI, exp_hi);
        check({tag, ".lo"}, LO, exp_lo);
    endtask

    initial begin
        int n;

        // Reset state
        step();
        step();
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.hi", HI, 32'd0);
        check("reset.lo", LO, 32'd0);
        rst_n = 1'b1;
        step();

        // mult -2 * 3 : HI/LO must not move while running
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult.busy_rise", {31'd0, busy}, 32'd1);
        check("mult.hi_mid", HI, 32'd0);
        busy_cycles(n);
        check("mult.cycles", n, 5);
        check("mult.hi", HI, 32'hFFFF_FFFF);
        check("mult.lo", LO, 32'hFFFF_FFFA);

        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // mthi / mtlo then divide by zero leaves HI/LO alone
        issue(3'd5, 32'h0000_1234, 32'd0);
        check("mthi.busy", {31'd0, busy}, 32'd0);
        check("mthi.hi", HI, 32'h0000_1234);
        issue(3'd6, 32'h0000_5678, 32'd0);
        check("mtlo.busy", {31'd0, busy}, 32'd0);
        check("mtlo.lo", LO, 32'h0000_5678);
        run_op("divz", 3'd3, 32'd5, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);

        // Reserved / none opcodes with start are ignored
        issue(3'd7, 32'hFFFF_FFFF, 32'd1);
        check("rsvd.busy", {31'd0, busy}, 32'd0);
        check("rsvd.lo", LO, 32'h0000_5678);

        // mtlo on the 2nd busy cycle of mult 3*4 is ignored
        issue(3'd1, 32'd3, 32'd4);
        step();
        start = 1'b1;
        md_op = 3'd6;
        A     = 32'h0000_AAAA;
        step();
        start = 1'b0;
        md_op = 3'd0;
        check("startrun.busy", {31'd0, busy}, 32'd1);
        check("startrun.lo_mid", LO, 32'h0000_5678);
        busy_cycles(n);
        check("startrun.cycles", n, 3);
        check("startrun.hi", HI, 32'd0);
        check("startrun.lo", LO, 32'd12);

        // mthi presented on the completion edge of mult 5*5 is ignored
        issue(3'd1, 32'd5, 32'd5);
        repeat (4) step();
        start = 1'b1;
        md_op = 3'd5;
        A     = 32'h0000_DEAD;
        step();
        start = 1'b0;
        md_op = 3'd0;
        check("startfall.busy", {31'd0, busy}, 32'd0);
        check("startfall.hi", HI, 32'd0);
        check("startfall.lo", LO, 32'd25);
        step();
        check("startfall.busy2", {31'd0, busy}, 32'd0);
        check("startfall.hi2", HI, 32'd0);

        // Asynchronous reset in the 3rd cycle of div 100/7, then no late writeback
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst.busy", {31'd0, busy}, 32'd0);
        check("arst.hi", HI, 32'd0);
        check("arst.lo", LO, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (12) step();
        check("arst.late_busy", {31'd0, busy}, 32'd0);
        check("arst.late_hi", HI, 32'd0);
        check("arst.late_lo", LO, 32'd0);

`ifdef MD_CANCEL_EN
        issue(3'd5, 32'h0000_0011, 32'd0);
        issue(3'd6, 32'h0000_0022, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel.busy", {31'd0, busy}, 32'd0);
        check("cancel.hi", HI, 32'h0000_0011);
        check("cancel.lo", LO, 32'h0000_0022);
        repeat (12) step();
        check("cancel.late_lo", LO, 32'h0000_0022);
        cancel = 1'b1;
        issue(3'd5, 32'h0000_0099, 32'd0);
        cancel = 1'b0;
        check("cancel.mthi", HI, 32'h0000_0011);
        run_op("cancel.mult", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
